// File: rtl/seq_divider_3bit.sv
// ---------------------------------------------------------------------------
// seq_divider_3bit
//
// Sequential restoring divider for unsigned operands. It produces one quotient
// bit per clock by trial-subtracting the divisor from a shifted partial
// remainder. The subtract is done as rem + ~{0,B} + 1, and the carry-out means
// "no borrow" (rem >= B).
//
// Parameters
//   WIDTH        operand / quotient / remainder width (default 3)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only in IDLE or DONE
//   A            dividend, captured on the accepting edge
//   B            divisor, captured on the accepting edge
//   Q            quotient (registered)
//   R            remainder (registered)
//   busy         high while iterating
//   done         one-cycle completion pulse
//   div_by_zero  high with done when B was 0; held until the next accept
//   dbg_state    current FSM state (0 = IDLE, 1 = CALC, 2 = DONE)
//
// Handshake: an operation is accepted on any rising edge where the FSM is in
// IDLE or DONE and start = 1. start is ignored in CALC. A and B only matter on
// the accepting edge. The result is valid in the single cycle where done = 1,
// and Q/R then hold until the next accept.
// ---------------------------------------------------------------------------
module seq_divider_3bit #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;

  // One restoring step, evaluated combinationally from the current registers.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH:0]   rem_next;
  logic             accept;

  always_comb begin
    // Shift the dividend MSB into the partial remainder.
    rem_sh    = (rem << 1) | {{WIDTH{1'b0}}, dividend[WIDTH-1]};
    // Subtract mode of the add/subtract datapath: invert the operand and add 1.
    // Bit WIDTH+1 is the carry-out, which is set exactly when rem_sh >= divisor.
    trial     = {1'b0, rem_sh} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
    no_borrow = trial[WIDTH+1];
    rem_next  = no_borrow ? trial[WIDTH:0] : rem_sh;
    accept    = start && ((state == IDLE) || (state == DONE));
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (state == DONE) state <= IDLE;
          if (accept) begin
            dividend    <= A;
            divisor     <= B;
            rem         <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            if (B != '0) begin
              state <= CALC;
              count <= CW'(WIDTH);
              busy  <= 1'b1;
            end else begin
              // Division by zero skips CALC and reports at once.
              state       <= DONE;
              count       <= '0;
              Q           <= '1;
              R           <= A;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end
          end
        end

        CALC: begin
          rem      <= rem_next;
          dividend <= dividend << 1;
          Q        <= {Q[WIDTH-2:0], no_borrow};
          count    <= count - CW'(1);
          if (count == CW'(1)) begin
            // Last iteration: publish the remainder together with done.
            R     <= rem_next[WIDTH-1:0];
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
